// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - operand/result handshake bundle for the digit-serial subtractor
interface serial_subtractor_if #(
  parameter int SIZE = 32
);
  logic            start;
  logic [SIZE-1:0] a;
  logic [SIZE-1:0] b;
  logic            bin;
  logic            busy;
  logic            done;
  logic [SIZE-1:0] d;
  logic            borrowout;
  logic            overflow;

  modport master (
    output start, a, b, bin,
    input  busy, done, d, borrowout, overflow
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, d, borrowout, overflow
  );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - digit-serial a - b - bin, LSB digit first, with start/busy/done
module serial_subtractor #(
  parameter int SIZE  = 32,
  parameter int DIGIT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  sub_if
);

  localparam int N  = SIZE / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [SIZE-1:0] a_q, a_d;
  logic [SIZE-1:0] b_q, b_d;
  logic [SIZE-1:0] res_q, res_d;
  logic            brw_q, brw_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sa_q, sa_d;
  logic            sb_q, sb_d;
  logic [SIZE-1:0] d_q, d_d;
  logic            bo_q, bo_d;
  logic            ovf_q, ovf_d;

  logic [DIGIT:0]        digit_sub;
  logic [SIZE+DIGIT-1:0] res_cat;
  logic [SIZE-1:0]       res_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      d_q     <= '0;
      bo_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      d_q     <= d_d;
      bo_q    <= bo_d;
      ovf_q   <= ovf_d;
    end
  end

  // The extra top bit of the digit difference is the borrow into the next digit.
  assign digit_sub = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, brw_q};
  assign res_cat   = {digit_sub[DIGIT-1:0], res_q};
  assign res_shift = res_cat[SIZE+DIGIT-1:DIGIT];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    d_d     = d_q;
    bo_d    = bo_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (sub_if.start) begin
          a_d     = sub_if.a;
          b_d     = sub_if.b;
          brw_d   = sub_if.bin;
          sa_d    = sub_if.a[SIZE-1];
          sb_d    = sub_if.b[SIZE-1];
          res_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        res_d = res_shift;
        brw_d = digit_sub[DIGIT];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          d_d     = res_shift;
          bo_d    = digit_sub[DIGIT];
          ovf_d   = (sa_q != sb_q) && (res_shift[SIZE-1] != sa_q);
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sub_if.busy      = (state_q == RUN);
  assign sub_if.done      = (state_q == DONE);
  assign sub_if.d         = d_q;
  assign sub_if.borrowout = bo_q;
  assign sub_if.overflow  = ovf_q;

endmodule
